// File: rtl/spike_pair_buffer.sv
// Spike pair buffer: keeps short pre/post spike histories stamped with a
// free-running timestamp, pairs each new spike with the newest valid
// partner and presents the signed time difference on a ready/valid output.
module spike_pair_buffer #(
  parameter int TS_W   = 9,
  parameter int DEPTH  = 3,
  parameter int WINDOW = 20,
  parameter int NID_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              tick_i,
  input  logic              pre_spike_i,
  input  logic              post_spike_i,
  input  logic [NID_W-1:0]  neuron_number_i,
  input  logic              delta_ready_i,
  output logic              delta_valid_o,
  output logic [TS_W:0]     delta_o,
  output logic [NID_W-1:0]  delta_nid_o,
  output logic [7:0]        drop_cnt_o,
  output logic [TS_W-1:0]   now_ts_o
);

  localparam logic [TS_W-1:0] WIN = TS_W'(WINDOW);

  // Age of an entry relative to the current timestamp, modulo 2^TS_W.
  function automatic logic [TS_W-1:0] age_f(input logic [TS_W-1:0] now, input logic [TS_W-1:0] ts);
    return now - ts;
  endfunction

  logic [TS_W-1:0]  now_q, now_d;
  logic [DEPTH-1:0] pre_v_q, pre_v_d, post_v_q, post_v_d;
  logic [TS_W-1:0]  pre_ts_q [DEPTH];
  logic [TS_W-1:0]  pre_ts_d [DEPTH];
  logic [TS_W-1:0]  post_ts_q [DEPTH];
  logic [TS_W-1:0]  post_ts_d [DEPTH];
  logic             valid_q, valid_d;
  logic [TS_W:0]    delta_q, delta_d;
  logic [NID_W-1:0] nid_q, nid_d;
  logic [7:0]       drop_q, drop_d;

  logic             pre_s, post_s;
  logic             pre_hit_s, post_hit_s;
  logic [TS_W-1:0]  pre_age_s, post_age_s;
  logic             pair_s;
  logic [TS_W:0]    pair_delta_s;
  logic [DEPTH-1:0] pre_aged_s, post_aged_s;

  // Spikes in a kill cycle are ignored entirely.
  assign pre_s  = pre_spike_i  & ~kill_i;
  assign post_s = post_spike_i & ~kill_i;

  // Find the newest valid entry of each history (lowest index wins) from pre-push contents.
  always_comb begin
    pre_hit_s  = 1'b0;
    pre_age_s  = '0;
    post_hit_s = 1'b0;
    post_age_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (pre_v_q[i]) begin
        pre_hit_s = 1'b1;
        pre_age_s = age_f(now_q, pre_ts_q[i]);
      end else begin
        pre_hit_s = pre_hit_s;
      end
      if (post_v_q[i]) begin
        post_hit_s = 1'b1;
        post_age_s = age_f(now_q, post_ts_q[i]);
      end else begin
        post_hit_s = post_hit_s;
      end
    end
  end

  // Pair selection: coincident spikes give zero, otherwise LTP (+age) or LTD (-age).
  always_comb begin
    pair_s       = 1'b0;
    pair_delta_s = '0;
    if (pre_s && post_s) begin
      pair_s       = 1'b1;
      pair_delta_s = '0;
    end else if (post_s && pre_hit_s) begin
      pair_s       = 1'b1;
      pair_delta_s = {1'b0, pre_age_s};
    end else if (pre_s && post_hit_s) begin
      pair_s       = 1'b1;
      pair_delta_s = (TS_W+1)'(0) - {1'b0, post_age_s};
    end else begin
      pair_s       = 1'b0;
    end
  end

  // History update: expire entries about to exceed the window, then shift-push new spikes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pre_aged_s[i]  = pre_v_q[i]  & ~(tick_i & (age_f(now_q, pre_ts_q[i])  >= WIN));
      post_aged_s[i] = post_v_q[i] & ~(tick_i & (age_f(now_q, post_ts_q[i]) >= WIN));
      pre_ts_d[i]    = pre_ts_q[i];
      post_ts_d[i]   = post_ts_q[i];
    end
    pre_v_d  = pre_aged_s;
    post_v_d = post_aged_s;
    if (kill_i) begin
      pre_v_d  = '0;
      post_v_d = '0;
    end else begin
      if (pre_s) begin
        for (int i = DEPTH - 1; i >= 1; i--) begin
          pre_v_d[i]  = pre_aged_s[i-1];
          pre_ts_d[i] = pre_ts_q[i-1];
        end
        pre_v_d[0]  = 1'b1;
        pre_ts_d[0] = now_q;
      end else begin
        pre_v_d = pre_aged_s;
      end
      if (post_s) begin
        for (int i = DEPTH - 1; i >= 1; i--) begin
          post_v_d[i]  = post_aged_s[i-1];
          post_ts_d[i] = post_ts_q[i-1];
        end
        post_v_d[0]  = 1'b1;
        post_ts_d[0] = now_q;
      end else begin
        post_v_d = post_aged_s;
      end
    end
  end

  // Timestamp, output register handshake and saturating drop counter.
  always_comb begin
    now_d   = tick_i ? now_q + TS_W'(1) : now_q;
    valid_d = valid_q;
    delta_d = delta_q;
    nid_d   = nid_q;
    drop_d  = drop_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (pair_s && (!valid_q || delta_ready_i)) begin
      valid_d = 1'b1;
      delta_d = pair_delta_s;
      nid_d   = neuron_number_i;
    end else if (pair_s) begin
      drop_d  = (drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end else if (valid_q && delta_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      now_q    <= '0;
      pre_v_q  <= '0;
      post_v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pre_ts_q[i]  <= '0;
        post_ts_q[i] <= '0;
      end
      valid_q  <= 1'b0;
      delta_q  <= '0;
      nid_q    <= '0;
      drop_q   <= 8'd0;
    end else begin
      now_q    <= now_d;
      pre_v_q  <= pre_v_d;
      post_v_q <= post_v_d;
      for (int i = 0; i < DEPTH; i++) begin
        pre_ts_q[i]  <= pre_ts_d[i];
        post_ts_q[i] <= post_ts_d[i];
      end
      valid_q  <= valid_d;
      delta_q  <= delta_d;
      nid_q    <= nid_d;
      drop_q   <= drop_d;
    end
  end

  assign delta_valid_o = valid_q;
  assign delta_o       = delta_q;
  assign delta_nid_o   = nid_q;
  assign drop_cnt_o    = drop_q;
  assign now_ts_o      = now_q;

endmodule

// File: tb/tb_spike_pair_buffer.sv
// Directed bench for spike_pair_buffer: table of two-spike pairing
// scenarios plus hand-written multi-cycle sequences.
module tb_spike_pair_buffer;

  localparam int TS_W  = 9;
  localparam int NID_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             kill = 1'b0;
  logic             tick = 1'b0;
  logic             pre = 1'b0;
  logic             post = 1'b0;
  logic [NID_W-1:0] nid = '0;
  logic             ready = 1'b1;
  logic             dvalid;
  logic [TS_W:0]    delta;
  logic [NID_W-1:0] dnid;
  logic [7:0]       drop;
  logic [TS_W-1:0]  now_ts;

  int checks = 0;
  int failures = 0;

  spike_pair_buffer #(.TS_W(TS_W), .DEPTH(3), .WINDOW(20), .NID_W(NID_W)) dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill), .tick_i(tick),
    .pre_spike_i(pre), .post_spike_i(post), .neuron_number_i(nid),
    .delta_ready_i(ready), .delta_valid_o(dvalid), .delta_o(delta),
    .delta_nid_o(dnid), .drop_cnt_o(drop), .now_ts_o(now_ts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic first_pre;
    logic both;
    int   gap;
    int   nid;
    logic exp_valid;
    int   exp_delta;
  } row_t;

  row_t rows [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic k, input logic t, input logic p, input logic q, input int n);
    kill = k; tick = t; pre = p; post = q; nid = NID_W'(n);
    step();
    kill = 1'b0; tick = 1'b0; pre = 1'b0; post = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic int sdelta();
    return int'($signed(delta));
  endfunction

  initial begin
    rows[0] = '{1'b1, 1'b0, 7,  'h2A, 1'b1, 7};
    rows[1] = '{1'b0, 1'b0, 4,  'h11, 1'b1, -4};
    rows[2] = '{1'b1, 1'b0, 20, 'h12, 1'b1, 20};
    rows[3] = '{1'b1, 1'b0, 21, 'h13, 1'b0, 0};
    rows[4] = '{1'b0, 1'b0, 21, 'h14, 1'b0, 0};
    rows[5] = '{1'b0, 1'b0, 1,  'h15, 1'b1, -1};
    rows[6] = '{1'b1, 1'b1, 3,  'h16, 1'b1, 0};
    rows[7] = '{1'b0, 1'b0, 20, 'h17, 1'b1, -20};

    // Reset state after driving some activity first.
    ready = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    do_reset();
    chk("rst_now", int'(now_ts), 0);
    chk("rst_valid", int'(dvalid), 0);
    chk("rst_delta", int'(delta), 0);
    chk("rst_nid", int'(dnid), 0);
    chk("rst_drop", int'(drop), 0);

    // Table: spike A at ts=5, gap ticks, spike B (or both), check the resulting pair.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      ticks(5);
      drive(1'b0, 1'b0, rows[r].first_pre, !rows[r].first_pre, 0);
      chk($sformatf("row%0d_first_nopair", r), int'(dvalid), 0);
      ticks(rows[r].gap);
      if (rows[r].both)
        drive(1'b0, 1'b0, 1'b1, 1'b1, rows[r].nid);
      else
        drive(1'b0, 1'b0, !rows[r].first_pre, rows[r].first_pre, rows[r].nid);
      chk($sformatf("row%0d_valid", r), int'(dvalid), int'(rows[r].exp_valid));
      if (rows[r].exp_valid) begin
        chk($sformatf("row%0d_delta", r), sdelta(), rows[r].exp_delta);
        chk($sformatf("row%0d_nid", r), int'(dnid), rows[r].nid);
      end
      chk($sformatf("row%0d_drop", r), int'(drop), 0);
      step();
      chk($sformatf("row%0d_consumed", r), int'(dvalid), 0);
    end

    // post at 10, pre at 14 -> -4; pre at 40 finds expired post -> nothing.
    do_reset();
    ticks(10);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h01);
    ticks(4);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 'h02);
    chk("ltd_delta", sdelta(), -4);
    ticks(26);
    chk("ltd_now40", int'(now_ts), 40);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 'h03);
    chk("ltd_expired_valid", int'(dvalid), 0);
    chk("ltd_expired_drop", int'(drop), 0);

    // Coincident spikes with prior history yield exactly one zero pair.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    ticks(2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h05);
    chk("coin_pre_ltp", sdelta(), 2);
    ticks(2);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 'h06);
    chk("coin_valid", int'(dvalid), 1);
    chk("coin_delta", sdelta(), 0);
    chk("coin_nid", int'(dnid), 'h06);
    step();
    chk("coin_single", int'(dvalid), 0);

    // Timestamp wrap: pre at 508, post at 3 -> +7; 21 ticks later pre is gone.
    do_reset();
    ticks(508);
    chk("wrap_now508", int'(now_ts), 508);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    ticks(7);
    chk("wrap_now3", int'(now_ts), 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h07);
    chk("wrap_delta", sdelta(), 7);
    ticks(21);
    chk("wrap_now24", int'(now_ts), 24);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h08);
    chk("wrap_expired", int'(dvalid), 0);

    // Backpressure: held pair stays put, 300 extra pairs saturate drop count.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    ticks(1);
    ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h33);
    chk("bp_first_delta", sdelta(), 1);
    for (int k = 0; k < 300; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, 'h44);
    chk("bp_held_valid", int'(dvalid), 1);
    chk("bp_held_delta", sdelta(), 1);
    chk("bp_held_nid", int'(dnid), 'h33);
    chk("bp_drop_sat", int'(drop), 255);
    ready = 1'b1;
    step();
    chk("bp_released", int'(dvalid), 0);
    ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h55);
    chk("bp_reload", int'(dvalid), 1);
    rst = 1'b1;
    post = 1'b1;
    step();
    rst = 1'b0;
    post = 1'b0;
    chk("rst_mid_valid", int'(dvalid), 0);
    chk("rst_mid_drop", int'(drop), 0);
    ready = 1'b1;

    // Full pre history keeps newest three; pairing uses newest; kill flushes.
    do_reset();
    ticks(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    ticks(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    ticks(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    ticks(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    ticks(2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h09);
    chk("full_delta", sdelta(), 2);
    chk("full_drop", int'(drop), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("kill_now", int'(now_ts), 7);
    chk("kill_valid", int'(dvalid), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 'h0A);
    chk("kill_nopair", int'(dvalid), 0);
    ready = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 'h0B);
    chk("kill2_pending", int'(dvalid), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("kill2_cleared", int'(dvalid), 0);
    chk("kill2_drop", int'(drop), 0);
    ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
